// File: rtl/main_buf_pkg.sv
// Shared types and constants for the main input buffer controller.
package main_buf_pkg;

  localparam int NUM_ELEMS_DEF = 9;
  localparam int BIAS_ELEMS    = 1;

  // Buffer lane selected by buf_sel; encoding 3 is never driven.
  typedef enum logic [1:0] {
    LANE_IFM  = 2'd0,
    LANE_WGT  = 2'd1,
    LANE_BIAS = 2'd2
  } lane_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_IFM   = 3'd1,
    ST_LD_WGT   = 3'd2,
    ST_LD_BIAS  = 3'd3,
    ST_WAIT_RSP = 3'd4
  } state_e;

  // Lane that a beat accepted in the given load state is written to.
  function automatic lane_e lane_of(input state_e st);
    case (st)
      ST_LD_WGT:  return LANE_WGT;
      ST_LD_BIAS: return LANE_BIAS;
      default:    return LANE_IFM;
    endcase
  endfunction

endpackage

// File: rtl/main_buf_wr_stage.sv
// Registered write stage: captures an accepted beat and presents it to the
// buffer one cycle later with its lane, element index and a write strobe.
module main_buf_wr_stage
  import main_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  lane_e                 lane_i,
  input  logic [3:0]            idx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            sel_o,
  output logic [3:0]            idx_o,
  output logic                  wr_en_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  lane_e                 sel_q,  sel_d;
  logic [3:0]            idx_q,  idx_d;
  logic                  wr_en_q, wr_en_d;

  // Next-state: load the address/data fields only on an accepted beat so they hold otherwise.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    data_d  = data_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wr_en_d = accept_i;
    if (accept_i) begin
      data_d = data_i;
      sel_d  = lane_i;
      idx_d  = idx_i;
    end
  end

  // Stage registers; a reset drops any strobe that is still pending.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data register is reset as well, because the buffer-facing outputs must read 0 in reset.
    if (rst) begin
      data_q  <= '0;
      sel_q   <= LANE_IFM;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      data_q  <= data_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign idx_o   = idx_q;
  assign wr_en_o = wr_en_q;

endmodule

// File: rtl/main_buf_ctrl.sv
// Main input buffer sequencer: loads ifm/wgt/bias beats for each tile,
// hands the resident tile to the PE array via valid_read/respond and
// repeats for the programmed number of tiles.
module main_buf_ctrl
  import main_buf_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ELEMS      = NUM_ELEMS_DEF,
  parameter int TILE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles,
  input  logic                      cfg_reuse_wgt,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     buf_data,
  output logic [1:0]                buf_sel,
  output logic                      buf_wr_en,
  output logic [3:0]                buf_idx,
  output logic                      valid_read,
  input  logic                      respond,
  output logic                      busy,
  output logic                      done
);

  localparam logic [3:0] LAST_ELEM = 4'(NUM_ELEMS - 1);
  localparam logic [3:0] LAST_BIAS = 4'(BIAS_ELEMS - 1);

  state_e                    state_q, state_d;
  logic [3:0]                elem_cnt_q, elem_cnt_d;
  logic [TILE_CNT_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_q, cfg_tiles_d;
  logic                      cfg_reuse_q, cfg_reuse_d;
  logic                      valid_read_q, valid_read_d;
  logic                      done_q, done_d;

  logic  loading;
  logic  accept;
  logic  elem_last;
  logic  tile_last;
  logic  skip_wgt;
  lane_e lane_cur;

  assign loading   = (state_q == ST_LD_IFM) || (state_q == ST_LD_WGT) ||
                     (state_q == ST_LD_BIAS);
  assign accept    = in_valid && loading;
  assign elem_last = (elem_cnt_q == LAST_ELEM);
  assign tile_last = ((tile_cnt_q + TILE_CNT_WIDTH'(1)) == cfg_tiles_q);
  // Weights and bias stay resident after the first tile when reuse is set.
  assign skip_wgt  = cfg_reuse_q && (tile_cnt_q != '0);
  assign lane_cur  = lane_of(state_q);

  // Next-state and counter logic for the load/handoff sequence.
  always_comb begin
    state_d      = state_q;
    elem_cnt_d   = elem_cnt_q;
    tile_cnt_d   = tile_cnt_q;
    cfg_tiles_d  = cfg_tiles_q;
    cfg_reuse_d  = cfg_reuse_q;
    valid_read_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_tiles_d = cfg_tiles;
          cfg_reuse_d = cfg_reuse_wgt;
          tile_cnt_d  = '0;
          elem_cnt_d  = '0;
          if (cfg_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LD_IFM;
          end
        end
      end

      ST_LD_IFM: begin
        if (accept) begin
          if (elem_last) begin
            elem_cnt_d = '0;
            state_d    = skip_wgt ? ST_WAIT_RSP : ST_LD_WGT;
          end else begin
            elem_cnt_d = elem_cnt_q + 4'd1;
          end
        end
      end

      ST_LD_WGT: begin
        if (accept) begin
          if (elem_last) begin
            elem_cnt_d = '0;
            state_d    = ST_LD_BIAS;
          end else begin
            elem_cnt_d = elem_cnt_q + 4'd1;
          end
        end
      end

      ST_LD_BIAS: begin
        if (accept && (elem_cnt_q == LAST_BIAS)) begin
          elem_cnt_d = '0;
          state_d    = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        // respond only counts once valid_read is actually visible.
        if (valid_read_q && respond) begin
          tile_cnt_d = tile_cnt_q + TILE_CNT_WIDTH'(1);
          if (tile_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LD_IFM;
          end
        end else begin
          valid_read_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and latched configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      elem_cnt_q   <= '0;
      tile_cnt_q   <= '0;
      cfg_tiles_q  <= '0;
      cfg_reuse_q  <= 1'b0;
      valid_read_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_cnt_q   <= elem_cnt_d;
      tile_cnt_q   <= tile_cnt_d;
      cfg_tiles_q  <= cfg_tiles_d;
      cfg_reuse_q  <= cfg_reuse_d;
      valid_read_q <= valid_read_d;
      done_q       <= done_d;
    end
  end

  main_buf_wr_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_stage (
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept),
    .data_i   (in_data),
    .lane_i   (lane_cur),
    .idx_i    (elem_cnt_q),
    .data_o   (buf_data),
    .sel_o    (buf_sel),
    .idx_o    (buf_idx),
    .wr_en_o  (buf_wr_en)
  );

  assign in_ready   = loading;
  assign busy       = (state_q != ST_IDLE);
  assign valid_read = valid_read_q;
  assign done       = done_q;

endmodule

// File: tb/tb_main_buf_ctrl.sv
// Bench for main_buf_ctrl: a beat-plan model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_main_buf_ctrl;

  localparam int DW = 32;
  localparam int NE = 9;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] cfg_tiles = '0;
  logic          cfg_reuse_wgt = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] buf_data;
  logic [1:0]    buf_sel;
  logic          buf_wr_en;
  logic [3:0]    buf_idx;
  logic          valid_read;
  logic          respond = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  main_buf_ctrl #(.DATA_WIDTH(DW), .NUM_ELEMS(NE), .TILE_CNT_WIDTH(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_tiles     (cfg_tiles),
    .cfg_reuse_wgt (cfg_reuse_wgt),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .buf_data      (buf_data),
    .buf_sel       (buf_sel),
    .buf_wr_en     (buf_wr_en),
    .buf_idx       (buf_idx),
    .valid_read    (valid_read),
    .respond       (respond),
    .busy          (busy),
    .done          (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is a list of tiles; each tile is a plan of (lane, idx) beats
  // that must be written in order, followed by a handoff phase.
  bit          m_busy, m_loading, m_wait, m_vr, m_done, m_wr_en, m_reuse;
  logic [31:0] m_data;
  int          m_sel, m_idx, m_total, m_tiles_done;
  int          plan_lane[$];
  int          plan_idx[$];

  function automatic void plan_tile(input int n);
    plan_lane.delete();
    plan_idx.delete();
    for (int i = 0; i < NE; i++) begin plan_lane.push_back(0); plan_idx.push_back(i); end
    if (!(m_reuse && n > 0)) begin
      for (int i = 0; i < NE; i++) begin plan_lane.push_back(1); plan_idx.push_back(i); end
      plan_lane.push_back(2);
      plan_idx.push_back(0);
    end
    m_loading = 1'b1;
    m_wait    = 1'b0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_loading = 0; m_wait = 0; m_vr = 0; m_done = 0; m_wr_en = 0;
      m_reuse = 0; m_data = '0; m_sel = 0; m_idx = 0; m_total = 0; m_tiles_done = 0;
      plan_lane.delete();
      plan_idx.delete();
    end else begin
      m_wr_en = 0;
      m_done  = 0;
      if (!m_busy) begin
        if (start) begin
          if (cfg_tiles == '0) m_done = 1;
          else begin
            m_busy = 1; m_total = int'(cfg_tiles); m_reuse = cfg_reuse_wgt;
            m_tiles_done = 0;
            plan_tile(0);
          end
        end
      end else if (m_loading) begin
        if (in_valid) begin
          m_wr_en = 1;
          m_data  = in_data;
          m_sel   = plan_lane.pop_front();
          m_idx   = plan_idx.pop_front();
          if (plan_lane.size() == 0) begin m_loading = 0; m_wait = 1; end
        end
      end else if (m_wait) begin
        if (!m_vr) m_vr = 1;
        else if (respond) begin
          m_vr = 0;
          m_tiles_done++;
          if (m_tiles_done == m_total) begin m_busy = 0; m_wait = 0; m_done = 1; end
          else plan_tile(m_tiles_done);
        end
      end
    end
  end

  // ---------------- compare process + event log ----------------
  logic [31:0] lg_data[$];
  int          lg_sel[$];
  int          lg_idx[$];
  int          done_cnt = 0, vr_rises = 0, vr_cycles = 0;
  bit          vr_prev = 0;

  initial forever begin
    @(negedge clk);
    check("in_ready",   32'(in_ready),   32'(m_loading));
    check("busy",       32'(busy),       32'(m_busy));
    check("valid_read", 32'(valid_read), 32'(m_vr));
    check("done",       32'(done),       32'(m_done));
    check("buf_wr_en",  32'(buf_wr_en),  32'(m_wr_en));
    check("buf_data",   buf_data,        m_data);
    check("buf_sel",    32'(buf_sel),    32'(m_sel));
    check("buf_idx",    32'(buf_idx),    32'(m_idx));
    if (buf_wr_en) begin
      lg_data.push_back(buf_data);
      lg_sel.push_back(int'(buf_sel));
      lg_idx.push_back(int'(buf_idx));
    end
    if (done) done_cnt++;
    if (valid_read) vr_cycles++;
    if (valid_read && !vr_prev) vr_rises++;
    vr_prev = valid_read;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int tiles, input bit reuse);
    @(negedge clk);
    start = 1'b1; cfg_tiles = TW'(tiles); cfg_reuse_wgt = reuse;
    @(negedge clk);
    start = 1'b0; cfg_tiles = '0; cfg_reuse_wgt = 1'b0;
  endtask

  // Offers n words base, base+1, ...; with gaps the offer alternates 1010.
  task automatic send(input int n, input logic [31:0] base, input bit gaps);
    int  sent = 0;
    int  cyc = 0;
    bit  ph = 0;
    while (sent < n && cyc < 400) begin
      if (gaps && ph) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = base + 32'(sent);
        if (in_ready) sent++;
      end
      ph = !ph;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (sent < n) check("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic wait_vr();
    int c = 0;
    while (!valid_read && c < 100) begin @(negedge clk); c++; end
    check("wait_valid_read", 32'(valid_read), 32'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin @(negedge clk); c++; end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_respond(input int delay);
    repeat (delay) @(negedge clk);
    respond = 1'b1;
    @(negedge clk);
    respond = 1'b0;
  endtask

  function automatic int tile_sel(input int k);
    return (k < 9) ? 0 : ((k < 18) ? 1 : 2);
  endfunction

  function automatic int tile_idx(input int k);
    return (k < 9) ? k : ((k < 18) ? k - 9 : 0);
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int b, d0, v0, c0;

    rst = 1'b1;
    tick(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(buf_wr_en), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single tile, 19 back-to-back beats 1..19, respond 3 cycles into valid_read.
    b = lg_data.size(); d0 = done_cnt; v0 = vr_rises;
    do_start(1, 0);
    send(19, 32'd1, 0);
    wait_vr();
    pulse_respond(2);
    tick(3);
    check("t1_strobes", 32'(lg_data.size() - b), 32'd19);
    if (lg_data.size() - b == 19) begin
      for (int k = 0; k < 19; k++) begin
        check("t1_data", lg_data[b+k], 32'(k + 1));
        check("t1_sel", 32'(lg_sel[b+k]), 32'(tile_sel(k)));
        check("t1_idx", 32'(lg_idx[b+k]), 32'(tile_idx(k)));
      end
    end
    check("t1_vr_rises", 32'(vr_rises - v0), 32'd1);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // Gapped stream, then in_valid held high through the handoff phase.
    b = lg_data.size(); d0 = done_cnt;
    do_start(1, 0);
    send(19, 32'h100, 1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    wait_vr();
    tick(1);
    pulse_respond(0);
    in_valid = 1'b0;
    tick(2);
    check("t2_strobes", 32'(lg_data.size() - b), 32'd19);
    if (lg_data.size() - b == 19) begin
      for (int k = 0; k < 19; k++)
        check("t2_idx", 32'(lg_idx[b+k]), 32'(tile_idx(k)));
      check("t2_last_data", lg_data[b+18], 32'h112);
    end
    check("t2_done", 32'(done_cnt - d0), 32'd1);

    // Weight reuse over 3 tiles: 19 + 9 + 9 beats.
    b = lg_data.size(); d0 = done_cnt; v0 = vr_rises;
    do_start(3, 1);
    send(19, 32'h1000, 0);
    wait_vr();
    pulse_respond(1);
    send(9, 32'h2000, 0);
    wait_vr();
    pulse_respond(0);
    send(9, 32'h3000, 0);
    wait_vr();
    pulse_respond(0);
    tick(3);
    check("t3_strobes", 32'(lg_data.size() - b), 32'd37);
    if (lg_data.size() - b == 37) begin
      check("t3_t1_first", lg_data[b+19], 32'h2000);
      check("t3_t1_sel", 32'(lg_sel[b+27]), 32'd0);
      check("t3_last_data", lg_data[b+36], 32'h3008);
      check("t3_last_idx", 32'(lg_idx[b+36]), 32'd8);
    end
    check("t3_vr_rises", 32'(vr_rises - v0), 32'd3);
    check("t3_done", 32'(done_cnt - d0), 32'd1);

    // Zero tiles: done next cycle, never busy.
    d0 = done_cnt;
    do_start(0, 0);
    tick(3);
    check("t4_done", 32'(done_cnt - d0), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);

    // start during LD_IFM with different cfg is ignored: run still ends after 1 tile.
    b = lg_data.size(); d0 = done_cnt; v0 = vr_rises;
    do_start(1, 0);
    send(3, 32'h50, 0);
    @(negedge clk);
    start = 1'b1; cfg_tiles = 16'd5; cfg_reuse_wgt = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_tiles = '0; cfg_reuse_wgt = 1'b0;
    send(16, 32'h53, 0);
    wait_vr();
    pulse_respond(0);
    tick(3);
    check("t5_strobes", 32'(lg_data.size() - b), 32'd19);
    check("t5_vr_rises", 32'(vr_rises - v0), 32'd1);
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);

    // Reset mid-LD_WGT right while the 4th wgt strobe is showing.
    d0 = done_cnt;
    do_start(2, 0);
    send(9, 32'h700, 0);
    send(4, 32'h800, 0);
    check("t6_pre_wr_en", 32'(buf_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_wr_en", 32'(buf_wr_en), 32'd0);
    check("t6_data", buf_data, 32'd0);
    check("t6_sel", 32'(buf_sel), 32'd0);
    check("t6_idx", 32'(buf_idx), 32'd0);
    check("t6_vr", 32'(valid_read), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    b = lg_data.size();
    do_start(1, 0);
    send(19, 32'h900, 0);
    wait_vr();
    pulse_respond(0);
    tick(2);
    check("t6_restart_n", 32'(lg_data.size() - b), 32'd19);
    if (lg_data.size() > b) begin
      check("t6_restart_data", lg_data[b], 32'h900);
      check("t6_restart_sel", 32'(lg_sel[b]), 32'd0);
      check("t6_restart_idx", 32'(lg_idx[b]), 32'd0);
    end

    // respond held high throughout: ignored while loading, one-cycle valid_read.
    d0 = done_cnt; v0 = vr_rises; c0 = vr_cycles;
    respond = 1'b1;
    do_start(1, 0);
    send(19, 32'hA00, 0);
    wait_idle();
    respond = 1'b0;
    tick(2);
    check("t7_vr_rises", 32'(vr_rises - v0), 32'd1);
    check("t7_vr_cycles", 32'(vr_cycles - c0), 32'd1);
    check("t7_done", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
